// File: rtl/rr_grant_fsm.sv
// rr_grant_fsm: Moore round-robin arbiter with a one-cycle idle gap between
// owners and a per-grant hold limit that forces rotation.
module rr_grant_fsm #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [HW-1:0]  r_hold_cnt;
    logic [IDW-1:0] r_owner;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_busy;
    logic           r_timeout;

    logic [IDW-1:0] w_winner;
    logic [IDW:0]   w_scan;
    logic [IDW-1:0] w_next_ptr;
    logic [IDW:0]   w_owner_inc;
    logic           w_any_req;
    logic           w_owner_req;
    logic           w_hold_max;

    assign w_any_req   = |req;
    assign w_owner_req = req[r_owner];
    assign w_hold_max  = (r_hold_cnt == HW'(MAX_HOLD - 1));

    // Rotating first-set-bit search starting at r_ptr; scanning offsets from
    // high to low lets the smallest offset overwrite and win.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_winner = '0;
        w_scan   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_scan = {1'b0, r_ptr} + (IDW + 1)'(i);
            if (w_scan >= (IDW + 1)'(N)) begin
                w_scan = w_scan - (IDW + 1)'(N);
            end
            if (req[w_scan[IDW-1:0]]) begin
                w_winner = w_scan[IDW-1:0];
            end
        end
    end

    // Pointer value one past the current owner, wrapping at N.
    always_comb begin
        w_owner_inc = {1'b0, r_owner} + 1'b1;
        if (w_owner_inc == (IDW + 1)'(N)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_owner_inc[IDW-1:0];
        end
    end

    // State, rotation bookkeeping and registered outputs, all with sync reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    r_timeout <= 1'b0;
                    if (w_any_req) begin
                        r_state    <= ST_GRANT;
                        r_owner    <= w_winner;
                        r_hold_cnt <= '0;
                        r_gnt      <= N'(1) << w_winner;
                        r_gnt_id   <= w_winner;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || w_hold_max) begin
                        // Voluntary release takes priority; only a still-held
                        // grant that hit the limit flags a timeout.
                        r_state   <= ST_GAP;
                        r_ptr     <= w_next_ptr;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= w_owner_req;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_timeout <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// tb_rr_grant_fsm: directed scenarios for rr_grant_fsm (N=4, MAX_HOLD=8).
// Outputs are checked 1 time unit after each rising edge, inputs change there too.
module tb_rr_grant_fsm;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int passed = 0;
    int total  = 0;

    rr_grant_fsm #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, gnt_id, busy, timeout}; busy is simply "gnt nonzero".
    function automatic logic [7:0] ev(input logic [3:0] g, input logic [1:0] id,
                                      input logic to);
        return {g, id, |g, to};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge with the given request vector, then release.
    task automatic do_reset(input logic [3:0] r);
        rst = 1'b0;
        req = r;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            step();
            e = ev(4'b0000, 2'd0, 1'b0);
            total++;
            if ({gnt, gnt_id, busy, timeout} !== e)
                $display("FAIL reset_hold c=%0d: got %b expected %b", c, {gnt, gnt_id, busy, timeout}, e);
            else passed++;
        end
        rst = 1'b1;
        step();
        e = ev(4'b0001, 2'd0, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL reset_first_grant: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
    endtask

    task automatic test_rotation();
        logic [7:0] e;
        do_reset(4'b1111);
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 2; c++) begin
                step();
                e = ev(4'b0001 << o, 2'(o), 1'b0);
                total++;
                if ({gnt, gnt_id, busy, timeout} !== e)
                    $display("FAIL rotation_grant o=%0d c=%0d: got %b expected %b", o, c, {gnt, gnt_id, busy, timeout}, e);
                else passed++;
            end
            req = 4'b1111 & ~(4'b0001 << o);
            step();
            e = ev(4'b0000, 2'(o), 1'b0);
            total++;
            if ({gnt, gnt_id, busy, timeout} !== e)
                $display("FAIL rotation_gap o=%0d: got %b expected %b", o, {gnt, gnt_id, busy, timeout}, e);
            else passed++;
            req = 4'b1111;
        end
        step();
        e = ev(4'b0001, 2'd0, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL rotation_wrap: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
    endtask

    task automatic test_forced_rotation();
        logic [7:0] e;
        logic [1:0] own;
        do_reset(4'b0101);
        for (int r = 0; r < 2; r++) begin
            own = (r == 0) ? 2'd0 : 2'd2;
            for (int c = 0; c < MAX_HOLD; c++) begin
                step();
                e = ev(4'b0001 << own, own, 1'b0);
                total++;
                if ({gnt, gnt_id, busy, timeout} !== e)
                    $display("FAIL forced_grant r=%0d c=%0d: got %b expected %b", r, c, {gnt, gnt_id, busy, timeout}, e);
                else passed++;
            end
            step();
            e = ev(4'b0000, own, 1'b1);
            total++;
            if ({gnt, gnt_id, busy, timeout} !== e)
                $display("FAIL forced_gap r=%0d: got %b expected %b", r, {gnt, gnt_id, busy, timeout}, e);
            else passed++;
        end
        step();
        e = ev(4'b0001, 2'd0, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL forced_back_to_0: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
    endtask

    task automatic test_lone_requester();
        logic [7:0] e;
        do_reset(4'b0100);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step();
                e = ev(4'b0100, 2'd2, 1'b0);
                total++;
                if ({gnt, gnt_id, busy, timeout} !== e)
                    $display("FAIL lone_grant r=%0d c=%0d: got %b expected %b", r, c, {gnt, gnt_id, busy, timeout}, e);
                else passed++;
            end
            step();
            e = ev(4'b0000, 2'd2, 1'b1);
            total++;
            if ({gnt, gnt_id, busy, timeout} !== e)
                $display("FAIL lone_gap r=%0d: got %b expected %b", r, {gnt, gnt_id, busy, timeout}, e);
            else passed++;
        end
        step();
        e = ev(4'b0100, 2'd2, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL lone_regrant: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
    endtask

    task automatic test_mid_grant_reset();
        logic [7:0] e;
        // Grant 1 to owner 0 (one cycle), then grant 2 to owner 1.
        do_reset(4'b1111);
        step();
        req = 4'b1110;
        step();
        req = 4'b1111;
        step();
        step();
        step();
        e = ev(4'b0010, 2'd1, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL midrst_pre: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
        rst = 1'b0;
        step();
        e = ev(4'b0000, 2'd0, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL midrst_cleared: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
        rst = 1'b1;
        req = 4'b0110;
        step();
        e = ev(4'b0010, 2'd1, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL midrst_next_owner: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
        // Owner 1 releases: ptr moves to 2 and owner 2 wins after the gap.
        req = 4'b0101;
        step();
        e = ev(4'b0000, 2'd1, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL midrst_gap: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
        step();
        e = ev(4'b0100, 2'd2, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL midrst_owner2: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
        // Reset with ptr=2: afterwards the scan must start from 0 again.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        e = ev(4'b0001, 2'd0, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL midrst_ptr_cleared: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
    endtask

    task automatic test_release_to_empty();
        logic [7:0] e;
        do_reset(4'b1000);
        step();
        e = ev(4'b1000, 2'd3, 1'b0);
        total++;
        if ({gnt, gnt_id, busy, timeout} !== e)
            $display("FAIL empty_grant: got %b expected %b", {gnt, gnt_id, busy, timeout}, e);
        else passed++;
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            e = ev(4'b0000, 2'd3, 1'b0);
            total++;
            if ({gnt, gnt_id, busy, timeout} !== e)
                $display("FAIL empty_idle c=%0d: got %b expected %b", c, {gnt, gnt_id, busy, timeout}, e);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        test_reset();
        test_rotation();
        test_forced_rotation();
        test_lone_requester();
        test_mid_grant_reset();
        test_release_to_empty();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
